// File: rtl/mem_wb_stage.sv
// MEM stage of the 16-bit MIPS pipeline: data memory, branch resolve and the
// MEM/WB register that feeds the register-file write port.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic              zero_in,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] st_data_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              pcsrc,
  output logic              wb_regwrite,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              addr_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];

  logic              regwrite_reg;
  logic              memtoreg_reg;
  logic [REG_W-1:0]  dest_reg;
  logic [DATA_W-1:0] alu_reg;
  logic [DATA_W-1:0] load_reg;
  logic              addr_err_reg;

  logic [ADDR_W-1:0] word_addr;
  logic              in_range;
  logic              mem_access;
  logic              store_en;
  logic [DATA_W-1:0] rd_data;
  logic              addr_err_next;

  assign pcsrc      = branch_in & zero_in;
  assign word_addr  = alu_res_in[ADDR_W-1:0];
  assign in_range   = (alu_res_in[DATA_W-1:ADDR_W] == '0);
  assign mem_access = memread_in | memwrite_in;
  assign store_en   = memwrite_in & ~stall & in_range;

  // Combinational read of the pre-edge contents gives read-old on a same-address store.
  assign rd_data = in_range ? mem_reg[word_addr] : '0;

  assign addr_err_next = addr_err_reg | (mem_access & ~in_range & ~stall);

  // One register per word so the whole array clears on reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
          mem_reg[gi] <= '0;
        end else if (store_en && (word_addr == ADDR_W'(gi))) begin
          mem_reg[gi] <= st_data_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      addr_err_reg <= 1'b0;
    end else begin
      addr_err_reg <= addr_err_next;
    end
  end

  // MEM/WB register: flush beats stall beats normal capture.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      dest_reg     <= '0;
      alu_reg      <= '0;
      load_reg     <= '0;
    end else if (flush) begin
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      dest_reg     <= '0;
      alu_reg      <= '0;
      load_reg     <= '0;
    end else if (!stall) begin
      regwrite_reg <= regwrite_in;
      memtoreg_reg <= memtoreg_in;
      dest_reg     <= dest_in;
      alu_reg      <= alu_res_in;
      load_reg     <= memread_in ? rd_data : '0;
    end
  end

  assign wb_regwrite = regwrite_reg;
  assign wb_addr     = dest_reg;
  assign wb_data     = memtoreg_reg ? load_reg : alu_reg;
  assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, store/load, read-old RAW, range
// errors, stall/flush and branch resolution.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        clear;
  logic        stall, flush, branch_in, memread_in, memwrite_in, zero_in;
  logic        regwrite_in, memtoreg_in;
  logic [15:0] alu_res_in, st_data_in;
  logic [3:0]  dest_in;
  logic        pcsrc, wb_regwrite, addr_err;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(16), .ADDR_W(6), .REG_W(4)) dut (
    .clk(clk), .clear(clear), .stall(stall), .flush(flush),
    .branch_in(branch_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .zero_in(zero_in), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .alu_res_in(alu_res_in), .st_data_in(st_data_in), .dest_in(dest_in),
    .pcsrc(pcsrc), .wb_regwrite(wb_regwrite), .wb_addr(wb_addr),
    .wb_data(wb_data), .addr_err(addr_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%04h expected=0x%04h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; branch_in = 0; memread_in = 0; memwrite_in = 0;
    zero_in = 0; regwrite_in = 0; memtoreg_in = 0;
    alu_res_in = 16'h0; st_data_in = 16'h0; dest_in = 4'h0;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    idle();
    memwrite_in = 1; alu_res_in = a; st_data_in = d;
  endtask

  task automatic load(input logic [15:0] a, input logic [3:0] rd);
    idle();
    memread_in = 1; memtoreg_in = 1; regwrite_in = 1; alu_res_in = a; dest_in = rd;
  endtask

  initial begin
    idle();
    clear = 0;
    repeat (2) tick();
    check("rst_regwrite", {15'h0, wb_regwrite}, 16'h0);
    check("rst_addr", {12'h0, wb_addr}, 16'h0);
    check("rst_data", wb_data, 16'h0);
    check("rst_err", {15'h0, addr_err}, 16'h0);
    clear = 1;

    // Reset asserted while a store to word 5 is presented.
    store(16'h0005, 16'h5555);
    regwrite_in = 1; dest_in = 4'h1;
    #2 clear = 0;
    tick();
    check("midrst_regwr", {15'h0, wb_regwrite}, 16'h0);
    check("midrst_data", wb_data, 16'h0);
    clear = 1;
    load(16'h0005, 4'h4);
    tick();
    check("midrst_mem5", wb_data, 16'h0);

    // Store then load the same word.
    store(16'h0005, 16'hBEEF);
    tick();
    load(16'h0005, 4'h3);
    tick();
    check("ld5_regwrite", {15'h0, wb_regwrite}, 16'h1);
    check("ld5_addr", {12'h0, wb_addr}, 16'h3);
    check("ld5_data", wb_data, 16'hBEEF);

    // Same-cycle load+store returns the old word.
    store(16'h0007, 16'h1111);
    tick();
    load(16'h0007, 4'h6);
    memwrite_in = 1; st_data_in = 16'h2222;
    tick();
    check("raw7_old", wb_data, 16'h1111);
    load(16'h0007, 4'h6);
    tick();
    check("raw7_new", wb_data, 16'h2222);

    // Top word of memory.
    store(16'h003F, 16'hA5A5);
    tick();
    load(16'h003F, 4'h1);
    tick();
    check("ld63_data", wb_data, 16'hA5A5);
    check("no_err_yet", {15'h0, addr_err}, 16'h0);

    // Out-of-range accesses.
    load(16'h0040, 4'h2);
    tick();
    check("oor_ld_data", wb_data, 16'h0);
    check("oor_ld_err", {15'h0, addr_err}, 16'h1);
    store(16'h0047, 16'hDEAD);
    tick();
    load(16'h0007, 4'h6);
    tick();
    check("oor_st_mem7", wb_data, 16'h2222);
    check("err_sticky", {15'h0, addr_err}, 16'h1);
    load(16'h0005, 4'h3);
    tick();
    check("ld5_again", wb_data, 16'hBEEF);
    check("err_sticky2", {15'h0, addr_err}, 16'h1);

    // Stall holds MEM/WB and blocks the store.
    store(16'h0009, 16'h9999);
    regwrite_in = 1; dest_in = 4'h8; stall = 1;
    tick();
    check("stall_regwr", {15'h0, wb_regwrite}, 16'h1);
    check("stall_addr", {12'h0, wb_addr}, 16'h3);
    check("stall_data", wb_data, 16'hBEEF);
    load(16'h0009, 4'h9);
    tick();
    check("stall_mem9", wb_data, 16'h0);
    idle();
    regwrite_in = 1; dest_in = 4'h7; alu_res_in = 16'h0011; stall = 1; flush = 1;
    tick();
    check("flush_regwr", {15'h0, wb_regwrite}, 16'h0);
    check("flush_data", wb_data, 16'h0);
    check("flush_addr", {12'h0, wb_addr}, 16'h0);

    // Branch resolution and plain ALU writeback.
    idle();
    branch_in = 1; zero_in = 1;
    #1 check("pcsrc_taken", {15'h0, pcsrc}, 16'h1);
    zero_in = 0;
    #1 check("pcsrc_nt", {15'h0, pcsrc}, 16'h0);
    idle();
    regwrite_in = 1; alu_res_in = 16'h00A5; dest_in = 4'h2;
    tick();
    check("alu_data", wb_data, 16'h00A5);
    check("alu_addr", {12'h0, wb_addr}, 16'h2);
    check("alu_regwr", {15'h0, wb_regwrite}, 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
